// File: rtl/l2_cache_control_pkg.sv
// Shared types and constants for the L2 cache control path.
package l2_cache_control_pkg;

   typedef logic [1:0] lc3b_l2_way;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } l2_ctrl_state_t;

   localparam logic [2:0] L2_PADDR_REQ     = 3'd0;
   localparam logic [2:0] L2_PADDR_WB_BASE = 3'd1;

   function automatic logic [3:0] way_onehot(input lc3b_l2_way w);
      return 4'b0001 << w;
   endfunction

endpackage

// File: rtl/l2_way_select.sv
// Hit detection and victim choice for one cache set; purely combinational.
// Lowest-indexed way wins for both hit and invalid-way victim selection.
module l2_way_select
   import l2_cache_control_pkg::*;
(
   input  logic [3:0]  match,
   input  logic [3:0]  valid,
   input  lc3b_l2_way  lru_out,
   output logic        hit,
   output lc3b_l2_way  hit_way,
   output lc3b_l2_way  victim_way
);

   logic [3:0] hit_vec;

   assign hit_vec = match & valid;
   assign hit     = |hit_vec;

   always_comb begin
      if (hit_vec[0])      hit_way = 2'd0;
      else if (hit_vec[1]) hit_way = 2'd1;
      else if (hit_vec[2]) hit_way = 2'd2;
      else if (hit_vec[3]) hit_way = 2'd3;
      else                 hit_way = 2'd0;
   end

   // An empty way is always preferred over evicting live data.
   always_comb begin
      if (!valid[0])      victim_way = 2'd0;
      else if (!valid[1]) victim_way = 2'd1;
      else if (!valid[2]) victim_way = 2'd2;
      else if (!valid[3]) victim_way = 2'd3;
      else                victim_way = lru_out;
   end

endmodule

// File: rtl/l2_cache_control.sv
// L2 control FSM: zero-wait hits, misses run WRITEBACK/ALLOCATE then replay in IDLE.
// L1 request is held until mem_resp; pmem requests are held until pmem_resp.
module l2_cache_control
   import l2_cache_control_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   input  logic                 pmem_resp,
   input  logic                 match0,
   input  logic                 match1,
   input  logic                 match2,
   input  logic                 match3,
   input  logic                 valid0_out,
   input  logic                 valid1_out,
   input  logic                 valid2_out,
   input  logic                 valid3_out,
   input  logic                 dirty0_out,
   input  logic                 dirty1_out,
   input  logic                 dirty2_out,
   input  logic                 dirty3_out,
   input  logic [1:0]           lru_out,
   output logic [1:0]           waymux_sel,
   output logic                 write_array_sel,
   output logic                 data0_load,
   output logic                 data1_load,
   output logic                 data2_load,
   output logic                 data3_load,
   output logic                 tag0_load,
   output logic                 tag1_load,
   output logic                 tag2_load,
   output logic                 tag3_load,
   output logic                 valid0_load,
   output logic                 valid1_load,
   output logic                 valid2_load,
   output logic                 valid3_load,
   output logic                 dirty0_load,
   output logic                 dirty1_load,
   output logic                 dirty2_load,
   output logic                 dirty3_load,
   output logic                 valid0_in,
   output logic                 valid1_in,
   output logic                 valid2_in,
   output logic                 valid3_in,
   output logic                 dirty0_in,
   output logic                 dirty1_in,
   output logic                 dirty2_in,
   output logic                 dirty3_in,
   output logic                 lru_load,
   output logic [1:0]           lru_in,
   output logic [2:0]           pmem_address_sel,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   l2_ctrl_state_t       state_q, state_d;
   lc3b_l2_way           victim_q, victim_d;
   logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;
   logic                 hit_inc, miss_inc;

   logic [3:0] match_vec, valid_vec, dirty_vec;
   logic       hit;
   lc3b_l2_way hit_way, victim_way;

   logic [3:0] data_ld, tag_ld, valid_ld, dirty_ld;
   logic [3:0] valid_dat, dirty_dat;

   assign match_vec = {match3, match2, match1, match0};
   assign valid_vec = {valid3_out, valid2_out, valid1_out, valid0_out};
   assign dirty_vec = {dirty3_out, dirty2_out, dirty1_out, dirty0_out};

   l2_way_select u_way_select (
      .match      (match_vec),
      .valid      (valid_vec),
      .lru_out    (lru_out),
      .hit        (hit),
      .hit_way    (hit_way),
      .victim_way (victim_way)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         victim_q   <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         if (hit_inc && !(&hit_cnt_q))
            hit_cnt_q <= hit_cnt_q + CNT_ONE;
         if (miss_inc && !(&miss_cnt_q))
            miss_cnt_q <= miss_cnt_q + CNT_ONE;
      end
   end

   always_comb begin
      state_d          = state_q;
      victim_d         = victim_q;
      mem_resp         = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      pmem_address_sel = L2_PADDR_REQ;
      write_array_sel  = 1'b0;
      waymux_sel       = (state_q == IDLE) ? hit_way : victim_q;
      lru_load         = 1'b0;
      lru_in           = hit_way;
      data_ld          = '0;
      tag_ld           = '0;
      valid_ld         = '0;
      dirty_ld         = '0;
      valid_dat        = '0;
      dirty_dat        = '0;
      hit_inc          = 1'b0;
      miss_inc         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               if (hit) begin
                  mem_resp = 1'b1;
                  lru_load = 1'b1;
                  hit_inc  = 1'b1;
                  // A simultaneous read+write is served as a write.
                  if (mem_write) begin
                     data_ld   = way_onehot(hit_way);
                     dirty_ld  = way_onehot(hit_way);
                     dirty_dat = way_onehot(hit_way);
                  end
               end else begin
                  victim_d = victim_way;
                  miss_inc = 1'b1;
                  state_d  = (valid_vec[victim_way] && dirty_vec[victim_way]) ? WRITEBACK : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            pmem_write       = 1'b1;
            pmem_address_sel = L2_PADDR_WB_BASE + {1'b0, victim_q};
            if (pmem_resp)
               state_d = ALLOCATE;
         end
         ALLOCATE: begin
            pmem_read       = 1'b1;
            write_array_sel = 1'b1;
            if (pmem_resp) begin
               data_ld   = way_onehot(victim_q);
               tag_ld    = way_onehot(victim_q);
               valid_ld  = way_onehot(victim_q);
               dirty_ld  = way_onehot(victim_q);
               valid_dat = way_onehot(victim_q);
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset aborts in-flight work: nothing may reach the arrays or the L1 side.
      if (reset) begin
         mem_resp  = 1'b0;
         lru_load  = 1'b0;
         data_ld   = '0;
         tag_ld    = '0;
         valid_ld  = '0;
         dirty_ld  = '0;
         hit_inc   = 1'b0;
         miss_inc  = 1'b0;
      end
   end

   assign data0_load  = data_ld[0];
   assign data1_load  = data_ld[1];
   assign data2_load  = data_ld[2];
   assign data3_load  = data_ld[3];
   assign tag0_load   = tag_ld[0];
   assign tag1_load   = tag_ld[1];
   assign tag2_load   = tag_ld[2];
   assign tag3_load   = tag_ld[3];
   assign valid0_load = valid_ld[0];
   assign valid1_load = valid_ld[1];
   assign valid2_load = valid_ld[2];
   assign valid3_load = valid_ld[3];
   assign dirty0_load = dirty_ld[0];
   assign dirty1_load = dirty_ld[1];
   assign dirty2_load = dirty_ld[2];
   assign dirty3_load = dirty_ld[3];
   assign valid0_in   = valid_dat[0];
   assign valid1_in   = valid_dat[1];
   assign valid2_in   = valid_dat[2];
   assign valid3_in   = valid_dat[3];
   assign dirty0_in   = dirty_dat[0];
   assign dirty1_in   = dirty_dat[1];
   assign dirty2_in   = dirty_dat[2];
   assign dirty3_in   = dirty_dat[3];

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: a cache-level reference model predicts each request's
// outcome; a monitor checks the DUT's strobes against it while a tag-array model closes the loop.
module tb_l2_cache_control;

   localparam int CW   = 16;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, mem_read, mem_write, pmem_resp;
   logic [3:0]    match_v, valid_v, dirty_v;
   logic [1:0]    lru_out;
   wire           mem_resp, pmem_read, pmem_write, write_array_sel, lru_load;
   wire  [1:0]    waymux_sel, lru_in;
   wire  [2:0]    pmem_address_sel;
   wire  [3:0]    data_ld, tag_ld, valid_ld, dirty_ld, valid_di, dirty_di;
   wire  [CW-1:0] hit_count, miss_count;
   wire           any_ld = |{data_ld, tag_ld, valid_ld, dirty_ld};

   l2_cache_control #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
      .match0(match_v[0]), .match1(match_v[1]), .match2(match_v[2]), .match3(match_v[3]),
      .valid0_out(valid_v[0]), .valid1_out(valid_v[1]), .valid2_out(valid_v[2]), .valid3_out(valid_v[3]),
      .dirty0_out(dirty_v[0]), .dirty1_out(dirty_v[1]), .dirty2_out(dirty_v[2]), .dirty3_out(dirty_v[3]),
      .lru_out(lru_out), .waymux_sel(waymux_sel), .write_array_sel(write_array_sel),
      .data0_load(data_ld[0]), .data1_load(data_ld[1]), .data2_load(data_ld[2]), .data3_load(data_ld[3]),
      .tag0_load(tag_ld[0]), .tag1_load(tag_ld[1]), .tag2_load(tag_ld[2]), .tag3_load(tag_ld[3]),
      .valid0_load(valid_ld[0]), .valid1_load(valid_ld[1]), .valid2_load(valid_ld[2]), .valid3_load(valid_ld[3]),
      .dirty0_load(dirty_ld[0]), .dirty1_load(dirty_ld[1]), .dirty2_load(dirty_ld[2]), .dirty3_load(dirty_ld[3]),
      .valid0_in(valid_di[0]), .valid1_in(valid_di[1]), .valid2_in(valid_di[2]), .valid3_in(valid_di[3]),
      .dirty0_in(dirty_di[0]), .dirty1_in(dirty_di[1]), .dirty2_in(dirty_di[2]), .dirty3_in(dirty_di[3]),
      .lru_load(lru_load), .lru_in(lru_in), .pmem_address_sel(pmem_address_sel),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] oh(input logic [1:0] w);
      oh = 4'b0001 << w;
   endfunction

   // Tag/valid/dirty arrays as the datapath would hold them, written only by DUT strobes.
   logic [15:0] cur_addr;
   logic        dp_clear;
   logic [8:0]  dp_tag [8][4];
   logic        dp_val [8][4];
   logic        dp_drt [8][4];
   wire  [2:0]  cidx = cur_addr[6:4];
   wire  [8:0]  ctg  = cur_addr[15:7];

   always_comb begin
      for (int w = 0; w < 4; w++) begin
         match_v[w] = (dp_tag[cidx][w] == ctg);
         valid_v[w] = dp_val[cidx][w];
         dirty_v[w] = dp_drt[cidx][w];
      end
   end

   always @(posedge clk) begin
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 4; w++) begin
            if (dp_clear) begin
               dp_tag[s][w] <= '0;
               dp_val[s][w] <= 1'b0;
               dp_drt[s][w] <= 1'b0;
            end else if (s == int'(cidx)) begin
               if (tag_ld[w])   dp_tag[s][w] <= ctg;
               if (valid_ld[w]) dp_val[s][w] <= valid_di[w];
               if (dirty_ld[w]) dp_drt[s][w] <= dirty_di[w];
            end
         end
      end
   end

   // Reference cache: what each line should hold after every completed request.
   logic [8:0] rtag [8][4];
   logic       rval [8][4];
   logic       rdrt [8][4];
   int         mhits, mmiss;

   typedef struct packed {
      logic       wr;
      logic       hit;
      logic [1:0] way;
      logic       wb;
   } exp_t;

   exp_t q[$];

   function automatic exp_t predict(input logic [15:0] a, input logic wr, input logic [1:0] lru);
      exp_t e;
      logic [2:0] ix;
      logic [8:0] tg;
      ix = a[6:4];
      tg = a[15:7];
      e.wr = wr; e.hit = 1'b0; e.way = 2'd0; e.wb = 1'b0;
      for (int w = 3; w >= 0; w--)
         if (rval[ix][w] && rtag[ix][w] == tg) begin e.hit = 1'b1; e.way = w[1:0]; end
      if (!e.hit) begin
         e.way = lru;
         for (int w = 3; w >= 0; w--)
            if (!rval[ix][w]) e.way = w[1:0];
         e.wb = rval[ix][e.way] && rdrt[ix][e.way];
      end
      return e;
   endfunction

   // Memory side: answers held requests after 0..3 cycles, sometimes pulses pmem_resp while idle.
   logic pmem_hold, spurious_en;
   initial begin : pmem_model
      int wait_cnt;
      wait_cnt  = -1;
      pmem_resp = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (pmem_resp) begin
            pmem_resp = 1'b0;
            wait_cnt  = -1;
         end else if ((pmem_read || pmem_write) && !pmem_hold) begin
            if (wait_cnt < 0) wait_cnt = $urandom_range(3, 0);
            if (wait_cnt == 0) pmem_resp = 1'b1;
            else wait_cnt--;
         end else begin
            wait_cnt = -1;
            if (spurious_en && $urandom_range(7, 0) == 0) pmem_resp = 1'b1;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      logic wb_done, al_done;
      int   age, cyc, al_cyc;
      wb_done = 1'b0; al_done = 1'b0; age = 0; cyc = 0; al_cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            q.delete();
            wb_done = 1'b0; al_done = 1'b0; age = 0;
         end else if (q.size() == 0) begin
            chk("idle_quiet", {mem_resp, pmem_read, pmem_write, lru_load, any_ld}, 0);
         end else begin
            e = q[0];
            if (pmem_write) begin
               chk("wb_expected", {e.wb, wb_done, al_done}, 3'b100);
               chk("wb_addr_sel", pmem_address_sel, 3'd1 + e.way);
               chk("wb_waymux", waymux_sel, e.way);
               chk("wb_noload", {any_ld, mem_resp, lru_load}, 0);
               if (pmem_resp) wb_done = 1'b1;
            end else if (pmem_read) begin
               chk("alloc_order", {e.hit, wb_done, al_done}, {1'b0, e.wb, 1'b0});
               chk("alloc_sel", {pmem_address_sel, write_array_sel, waymux_sel}, {3'd0, 1'b1, e.way});
               if (pmem_resp) begin
                  chk("alloc_loads", {data_ld, tag_ld, valid_ld, dirty_ld}, {4{oh(e.way)}});
                  chk("alloc_data", {valid_di[e.way], dirty_di[e.way], mem_resp}, 3'b100);
                  al_done = 1'b1;
                  al_cyc  = cyc;
               end else begin
                  chk("alloc_wait_noload", {any_ld, mem_resp, lru_load}, 0);
               end
            end else if (mem_resp) begin
               if (e.hit) chk("hit_latency", age, 0);
               else       chk("replay_gap", al_done ? (cyc - al_cyc) : -1, 1);
               chk("resp_lru", {lru_load, lru_in, waymux_sel, pmem_address_sel}, {1'b1, e.way, e.way, 3'd0});
               if (e.wr) begin
                  chk("wr_loads", {data_ld, tag_ld, valid_ld, dirty_ld}, {oh(e.way), 4'b0, 4'b0, oh(e.way)});
                  chk("wr_data", {dirty_di[e.way], write_array_sel}, 2'b10);
               end else begin
                  chk("rd_noload", any_ld, 0);
               end
               void'(q.pop_front());
               wb_done = 1'b0; al_done = 1'b0; age = 0;
            end else begin
               chk("wait_quiet", {lru_load, any_ld}, 0);
               age++;
            end
         end
      end
   end

   // Issues one request (called #1 after a rising edge) and holds it until mem_resp.
   task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] lru);
      exp_t e;
      logic [2:0] ix;
      logic       ok;
      int         n;
      ix = a[6:4];
      e  = predict(a, wr, lru);
      q.push_back(e);
      if (mhits < MAXC) mhits++;
      if (!e.hit && mmiss < MAXC) mmiss++;
      cur_addr  = a;
      lru_out   = lru;
      mem_read  = rd;
      mem_write = wr;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_resp && n < 200);
      if (!mem_resp) begin
         $display("FAIL req_timeout: addr 0x%0h got no mem_resp within %0d cycles", a, n);
         $fatal(1, "request did not complete");
      end
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      rtag[ix][e.way] = a[15:7];
      rval[ix][e.way] = 1'b1;
      if (!e.hit) rdrt[ix][e.way] = 1'b0;
      if (wr)     rdrt[ix][e.way] = 1'b1;
      chk("hit_count", hit_count, mhits);
      chk("miss_count", miss_count, mmiss);
      ok = 1'b1;
      for (int w = 0; w < 4; w++) begin
         if (dp_val[ix][w] !== rval[ix][w]) ok = 1'b0;
         if (rval[ix][w] && (dp_tag[ix][w] !== rtag[ix][w] || dp_drt[ix][w] !== rdrt[ix][w])) ok = 1'b0;
      end
      chk("array_state", ok, 1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      exp_t e;
      int   n;
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; cur_addr = '0; lru_out = '0;
      dp_clear = 1'b1; pmem_hold = 1'b0; spurious_en = 1'b0;
      mhits = 0; mmiss = 0;
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 4; w++) begin rtag[s][w] = '0; rval[s][w] = 1'b0; rdrt[s][w] = 1'b0; end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; dp_clear = 1'b0;
      @(negedge clk);
      chk("rst_counters", {hit_count, miss_count}, 0);
      chk("rst_outputs", {mem_resp, pmem_read, pmem_write, pmem_address_sel, write_array_sel, lru_load, any_ld}, 0);
      @(posedge clk); #1;

      // Cold miss, re-read hit, write hit on 0x0080.
      do_req(1'b1, 1'b0, 16'h0080, 2'd0);
      do_req(1'b1, 1'b0, 16'h0080, 2'd3);
      do_req(1'b0, 1'b1, 16'h0080, 2'd2);
      // Fill the rest of set 0, dirty way0, then force its eviction.
      do_req(1'b1, 1'b0, 16'h0100, 2'd0);
      do_req(1'b1, 1'b0, 16'h0180, 2'd0);
      do_req(1'b1, 1'b0, 16'h0200, 2'd0);
      do_req(1'b0, 1'b1, 16'h0080, 2'd1);
      do_req(1'b1, 1'b0, 16'h0280, 2'd0);
      do_req(1'b1, 1'b1, 16'h0100, 2'd2);

      spurious_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [8:0] tg;
         logic [2:0] ix;
         logic [3:0] off;
         int         kind;
         tg   = 9'($urandom_range(6, 1));
         ix   = 3'($urandom_range(1, 0));
         off  = 4'($urandom_range(15, 0));
         kind = $urandom_range(2, 0);
         do_req(kind != 1, kind != 0, {tg, ix, off}, 2'($urandom_range(3, 0)));
      end

      // Reset while ALLOCATE waits on memory.
      spurious_en = 1'b0;
      pmem_hold   = 1'b1;
      e = predict(16'h00F0, 1'b0, 2'd0);
      q.push_back(e);
      cur_addr = 16'h00F0; lru_out = 2'd0; mem_read = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pmem_read && n < 20);
      chk("abort_reach_alloc", pmem_read, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; mem_read = 1'b0;
      mhits = 0; mmiss = 0;
      @(negedge clk);
      chk("abort_pmem", {pmem_read, pmem_write}, 0);
      chk("abort_counters", {hit_count, miss_count}, 0);
      chk("abort_noload", {any_ld, mem_resp, lru_load}, 0);
      chk("abort_array", {dp_val[7][0], dp_val[7][1], dp_val[7][2], dp_val[7][3]}, 0);
      pmem_hold = 1'b0;
      @(posedge clk); #1;
      do_req(1'b1, 1'b0, 16'h00F0, 2'd0);

      // Hit counter must pin at all-ones.
      spurious_en = 1'b1;
      for (int i = 0; i < (1 << CW) + 2; i++)
         do_req(1'b1, 1'b0, 16'h0080, 2'($urandom_range(3, 0)));
      chk("sat_hit_count", hit_count, {CW{1'b1}});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
